// File: rtl/note_link_pkg.sv
// Shared constants and FSM state type for the note link receiver.
// Frame geometry defaults live here so the bench and RTL agree.
package note_link_pkg;

  localparam int SLOTS_PER_FRAME = 64;
  localparam int NUM_NOTES_DEF   = 48;
  localparam int PAD_SLOTS_DEF   = 15;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    PAD
  } state_t;

endpackage

// File: rtl/note_deserializer_if.sv
// Serial note link plus the recovered-vector status bundle.
// master drives the line side, slave is the receiving endpoint.
interface note_deserializer_if
  import note_link_pkg::*;
#(
  parameter int NUM_NOTES = NUM_NOTES_DEF
);

  logic                 note_serial_sync;
  logic                 note_serial_data;
  logic [NUM_NOTES-1:0] notes;
  logic                 notes_valid;
  logic                 frame_err;
  logic [7:0]           err_count;
  logic                 link_up;

  modport master (
    output note_serial_sync,
    output note_serial_data,
    input  notes,
    input  notes_valid,
    input  frame_err,
    input  err_count,
    input  link_up
  );

  modport slave (
    input  note_serial_sync,
    input  note_serial_data,
    output notes,
    output notes_valid,
    output frame_err,
    output err_count,
    output link_up
  );

endinterface

// File: rtl/note_deserializer_bit_sync.sv
// Two-flop synchronizer for one asynchronous input bit.
// Resets to 0 so the link looks idle right after reset.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/note_deserializer.sv
// Recovers the note vector from the sync/data serial pair and
// publishes it atomically with error and link-status flags.
module note_deserializer
  import note_link_pkg::*;
#(
  parameter int BIT_CYCLES     = 8192,
  parameter int NUM_NOTES      = NUM_NOTES_DEF,
  parameter int PAD_SLOTS      = PAD_SLOTS_DEF,
  parameter int SYNC_TOL       = BIT_CYCLES / 8,
  parameter int TIMEOUT_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  note_deserializer_if.slave link
);

  localparam int TW = $clog2(BIT_CYCLES) + 1;
  localparam int SW = $clog2(BIT_CYCLES + SYNC_TOL + 2);
  localparam int MX = (NUM_NOTES > PAD_SLOTS) ? NUM_NOTES : PAD_SLOTS;
  localparam int CW = $clog2(MX) + 1;
  localparam int WD = TIMEOUT_FRAMES * SLOTS_PER_FRAME * BIT_CYCLES;
  localparam int WW = $clog2(WD + 1);

  localparam logic [TW-1:0] HALF = TW'(BIT_CYCLES / 2);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);
  localparam logic [SW-1:0] SMIN = SW'(BIT_CYCLES - SYNC_TOL);
  localparam logic [SW-1:0] SMAX = SW'(BIT_CYCLES + SYNC_TOL);
  localparam logic [CW-1:0] DLST = CW'(NUM_NOTES - 1);
  localparam logic [CW-1:0] PLST = CW'(PAD_SLOTS - 1);
  localparam logic [WW-1:0] WLD  = WW'(WD);
  localparam logic [WW-1:0] WONE = WW'(1);

  logic s_sync;
  logic s_data;
  logic sync_q;
  logic rise;
  logic fall;
  logic sample;

  state_t               state, state_n;
  logic [TW-1:0]        tmr, tmr_n;
  logic [SW-1:0]        scnt, scnt_n;
  logic [CW-1:0]        slot, slot_n;
  logic [NUM_NOTES-1:0] shreg, shreg_n;
  logic                 commit;
  logic                 err;

  logic [NUM_NOTES-1:0] notes;
  logic                 notes_valid;
  logic                 frame_err;
  logic [7:0]           err_count;
  logic                 link_up;
  logic [WW-1:0]        wd;

  bit_sync u_sync_s (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (link.note_serial_sync),
    .q    (s_sync)
  );

  bit_sync u_sync_d (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (link.note_serial_data),
    .q    (s_data)
  );

  assign rise   = s_sync & ~sync_q;
  assign fall   = ~s_sync & sync_q;
  assign sample = (tmr == HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sync_q <= 1'b0;
      tmr    <= '0;
      scnt   <= '0;
      slot   <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      sync_q <= s_sync;
      tmr    <= tmr_n;
      scnt   <= scnt_n;
      slot   <= slot_n;
      shreg  <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = (tmr == LAST) ? '0 : tmr + TW'(1);
    scnt_n  = scnt;
    slot_n  = slot;
    shreg_n = shreg;
    commit  = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n = SYNC;
          tmr_n   = '0;
          scnt_n  = SW'(1);
        end
      end
      SYNC: begin
        if (fall) begin
          if (scnt >= SMIN && scnt <= SMAX) begin
            state_n = DATA;
            tmr_n   = TW'(1);
            slot_n  = '0;
          end else begin
            err     = 1'b1;
            state_n = IDLE;
          end
        end else if (scnt > SMAX) begin
          // overlong sync: IDLE only re-arms after sync falls
          err     = 1'b1;
          state_n = IDLE;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      DATA: begin
        if (sample) begin
          if (s_sync) begin
            err     = 1'b1;
            state_n = IDLE;
          end else begin
            shreg_n = {s_data, shreg[NUM_NOTES-1:1]};
            slot_n  = slot + CW'(1);
            if (slot == DLST) begin
              state_n = PAD;
              slot_n  = '0;
            end
          end
        end
      end
      PAD: begin
        if (sample) begin
          if (s_sync || s_data) begin
            err     = 1'b1;
            state_n = IDLE;
          end else if (slot == PLST) begin
            commit  = 1'b1;
            state_n = IDLE;
          end else begin
            slot_n = slot + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      notes       <= '0;
      notes_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
      link_up     <= 1'b0;
      wd          <= '0;
    end else begin
      notes_valid <= commit;
      frame_err   <= err;
      if (err && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      // commit beats expiry in the same cycle
      if (commit) begin
        notes   <= shreg;
        wd      <= WLD;
        link_up <= 1'b1;
      end else if (wd == WONE) begin
        wd      <= '0;
        link_up <= 1'b0;
        notes   <= '0;
      end else if (wd != '0) begin
        wd <= wd - WONE;
      end
    end
  end

  assign link.notes       = notes;
  assign link.notes_valid = notes_valid;
  assign link.frame_err   = frame_err;
  assign link.err_count   = err_count;
  assign link.link_up     = link_up;

endmodule
